// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bus: PC adder/hazard/branch inputs toward fetch_ctrl,
// next-PC and IF/ID control back out.
interface fetch_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] initPC;
  logic [WIDTH-1:0] incPC;
  logic             stall;
  logic             imem_ready;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jmp;
  logic [WIDTH-1:0] jmp_target;
  logic [WIDTH-1:0] nextPC;
  logic             pc_we;
  logic             if_valid;
  logic             ifid_flush;
  logic             redirect_pend;

  modport master (
    output initPC, incPC, stall, imem_ready, br_taken, br_target, jmp, jmp_target,
    input  nextPC, pc_we, if_valid, ifid_flush, redirect_pend
  );

  modport slave (
    input  initPC, incPC, stall, imem_ready, br_taken, br_target, jmp, jmp_target,
    output nextPC, pc_we, if_valid, ifid_flush, redirect_pend
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: boot hold, imem wait states, stalls and redirects.
// Define FETCH_DELAY_SLOT_EN to keep the instruction fetched in a redirect cycle.
module fetch_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  fetch_ctrl_if.slave bus
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state, stateNext;
  logic [CntW-1:0]   bootCnt, bootCntNext;
  logic              pendV, pendVNext;
  logic [WIDTH-1:0]  pendPC, pendPCNext;

  logic [WIDTH-1:0]  nextPC;
  logic              pcWe;
  logic              ifValid;
  logic              ifidFlush;
  logic              redir;
  logic [WIDTH-1:0]  target;
  logic              advance;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      bootCnt <= CntW'(BOOT_CYCLES - 1);
      pendV   <= 1'b0;
      pendPC  <= '0;
    end else begin
      state   <= stateNext;
      bootCnt <= bootCntNext;
      pendV   <= pendVNext;
      pendPC  <= pendPCNext;
    end
  end

  // Next-state, next-PC mux and fetch controls
  always_comb begin
    stateNext   = state;
    bootCntNext = bootCnt;
    pendVNext   = pendV;
    pendPCNext  = pendPC;
    nextPC      = bus.incPC;
    pcWe        = 1'b0;
    ifValid     = 1'b0;
    ifidFlush   = 1'b0;
    redir       = bus.jmp | bus.br_taken;
    target      = bus.jmp ? bus.jmp_target : bus.br_target;
    advance     = 1'b0;

    case (state)
      BOOT: begin
        nextPC    = bus.initPC;
        pcWe      = 1'b1;
        ifidFlush = 1'b1;
        if (bootCnt == '0) stateNext = RUN;
        else               bootCntNext = bootCnt - CntW'(1);
      end
      RUN, WAIT: begin
        advance = bus.imem_ready & ~bus.stall;
        if (advance) begin
          pcWe      = 1'b1;
          pendVNext = 1'b0;
          stateNext = RUN;
          if (redir)      nextPC = target;
          else if (pendV) nextPC = pendPC;
`ifdef FETCH_DELAY_SLOT_EN
          ifValid   = 1'b1;
          ifidFlush = 1'b0;
`else
          // The slot fetched alongside an applied redirect is wrong-path
          ifValid   = ~(redir | pendV);
          ifidFlush = redir | pendV;
`endif
        end else begin
          if (redir) begin
            pendVNext  = 1'b1;
            pendPCNext = target;
          end
          if (state == RUN && !bus.stall) stateNext = WAIT;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  assign bus.nextPC        = nextPC;
  assign bus.pc_we         = pcWe;
  assign bus.if_valid      = ifValid;
  assign bus.ifid_flush    = ifidFlush;
  assign bus.redirect_pend = pendV;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven scoreboard bench for fetch_ctrl with a PC-register model.
module tb_fetch_ctrl;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  typedef struct {
    string       name;
    bit          rst;
    bit          stall;
    bit          rdy;
    bit          br;
    logic [31:0] brT;
    bit          jmp;
    logic [31:0] jmpT;
    logic [31:0] eNext;
    bit          eWe;
    bit          eValid;
    bit          eFlush;
    bit          ePend;
    bit          chk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] curPC;
  int          nChecks = 0;
  int          nFail   = 0;
  vec_t        tbl[$];
  vec_t        expQ[$];

  fetch_ctrl_if #(.WIDTH(32)) bus ();

  fetch_ctrl #(.WIDTH(32), .BOOT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.initPC = 32'h0000_1000;
  assign bus.incPC  = curPC + 32'd4;

  function automatic vec_t mk(string name, bit r, bit st, bit rdy, bit br, logic [31:0] brT,
                              bit jmp, logic [31:0] jmpT, logic [31:0] eNext, bit eWe,
                              bit eValid, bit eFlush, bit ePend, bit chk = 1'b1);
    vec_t v;
    v.name = name; v.rst = r; v.stall = st; v.rdy = rdy; v.br = br; v.brT = brT;
    v.jmp = jmp; v.jmpT = jmpT; v.eNext = eNext; v.eWe = eWe; v.eValid = eValid;
    v.eFlush = eFlush; v.ePend = ePend; v.chk = chk;
    return v;
  endfunction

  task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst            = v.rst;
    bus.stall      = v.stall;
    bus.imem_ready = v.rdy;
    bus.br_taken   = v.br;
    bus.br_target  = v.brT;
    bus.jmp        = v.jmp;
    bus.jmp_target = v.jmpT;
    if (v.chk) expQ.push_back(v);
    #1;
    if (v.chk) begin
      e = expQ.pop_front();
      cmp(e.name, "nextPC", bus.nextPC, e.eNext);
      cmp(e.name, "pc_we", 32'(bus.pc_we), 32'(e.eWe));
      cmp(e.name, "if_valid", 32'(bus.if_valid), 32'(e.eValid));
      cmp(e.name, "ifid_flush", 32'(bus.ifid_flush), 32'(e.eFlush));
      cmp(e.name, "redirect_pend", 32'(bus.redirect_pend), 32'(e.ePend));
    end
    @(posedge clk);
    #1;
    if (v.chk && v.eWe) curPC = v.eNext;
  endtask

  initial begin
    bit dv;
    bit df;
    dv = DS;
    df = ~DS;
    rst = 1'b1; curPC = 32'h0;
    bus.stall = 1'b0; bus.imem_ready = 1'b0; bus.br_taken = 1'b0; bus.jmp = 1'b0;
    bus.br_target = '0; bus.jmp_target = '0;

    // boot, wait states, simultaneous redirect, stalled redirect
    tbl.push_back(mk("rst",       1,0,0, 0,0,          0,0,       32'h0,       0,0,0,0, 0));
    tbl.push_back(mk("boot0",     0,0,1, 0,0,          0,0,       32'h1000,    1,0,1,0));
    tbl.push_back(mk("boot1_ign", 0,0,1, 1,32'hDEAD,   0,0,       32'h1000,    1,0,1,0));
    tbl.push_back(mk("run1000",   0,0,1, 0,0,          0,0,       32'h1004,    1,1,0,0));
    tbl.push_back(mk("run1004",   0,0,1, 0,0,          0,0,       32'h1008,    1,1,0,0));
    tbl.push_back(mk("wait1",     0,0,0, 0,0,          0,0,       32'h100C,    0,0,0,0));
    tbl.push_back(mk("wait2",     0,0,0, 0,0,          0,0,       32'h100C,    0,0,0,0));
    tbl.push_back(mk("wait3",     0,0,0, 0,0,          0,0,       32'h100C,    0,0,0,0));
    tbl.push_back(mk("waitdone",  0,0,1, 0,0,          0,0,       32'h100C,    1,1,0,0));
    tbl.push_back(mk("jmp_prio",  0,0,1, 1,32'h2000,   1,32'h3000,32'h3000,    1,dv,df,0));
    tbl.push_back(mk("stall_br",  0,1,1, 1,32'h2400,   0,0,       32'h3004,    0,0,0,0));
    tbl.push_back(mk("stall_hold",0,1,1, 0,0,          0,0,       32'h3004,    0,0,0,1));
    tbl.push_back(mk("pend_apply",0,0,1, 0,0,          0,0,       32'h2400,    1,dv,df,1));
    tbl.push_back(mk("post_pend", 0,0,1, 0,0,          0,0,       32'h2404,    1,1,0,0));
    // latest pending redirect wins; stall extends WAIT
    tbl.push_back(mk("to_wait",   0,0,0, 0,0,          0,0,       32'h2408,    0,0,0,0));
    tbl.push_back(mk("pend500",   0,0,0, 1,32'h500,    0,0,       32'h2408,    0,0,0,0));
    tbl.push_back(mk("pend600",   0,0,0, 0,0,          1,32'h600, 32'h2408,    0,0,0,1));
    tbl.push_back(mk("wait_stall",0,1,1, 0,0,          0,0,       32'h2408,    0,0,0,1));
    tbl.push_back(mk("apply600",  0,0,1, 0,0,          0,0,       32'h600,     1,dv,df,1));
    tbl.push_back(mk("run600",    0,0,1, 0,0,          0,0,       32'h604,     1,1,0,0));
    // reset in WAIT with a redirect pending
    tbl.push_back(mk("to_wait2",  0,0,0, 0,0,          0,0,       32'h608,     0,0,0,0));
    tbl.push_back(mk("pend700",   0,0,0, 1,32'h700,    0,0,       32'h608,     0,0,0,0));
    tbl.push_back(mk("rst_wait",  1,0,0, 0,0,          0,0,       32'h608,     0,0,0,1));
    tbl.push_back(mk("reboot0",   0,0,1, 0,0,          0,0,       32'h1000,    1,0,1,0));
    tbl.push_back(mk("reboot1",   0,0,1, 0,0,          0,0,       32'h1000,    1,0,1,0));
    // unaligned/top-of-space target and adder wrap
    tbl.push_back(mk("br_top",    0,0,1, 1,32'hFFFF_FFFC,0,0,     32'hFFFF_FFFC,1,dv,df,0));
    tbl.push_back(mk("wrap",      0,0,1, 0,0,          0,0,       32'h0,       1,1,0,0));
    tbl.push_back(mk("stall_nordy",0,1,0,0,0,          0,0,       32'h4,       0,0,0,0));
    tbl.push_back(mk("still_run", 0,0,1, 0,0,          0,0,       32'h4,       1,1,0,0));
    // live redirect beats a pending one
    tbl.push_back(mk("pend900",   0,1,1, 1,32'h900,    0,0,       32'h8,       0,0,0,0));
    tbl.push_back(mk("live_a00",  0,0,1, 0,0,          1,32'hA01, 32'hA01,     1,dv,df,1));
    tbl.push_back(mk("after_a00", 0,0,1, 0,0,          0,0,       32'hA05,     1,1,0,0));

    foreach (tbl[i]) step(tbl[i]);

    // reset held for several cycles: boot count restarts only when rst drops
    step(mk("rst_a",   1,0,1, 0,0, 0,0, 32'h0,    0,0,0,0, 0));
    step(mk("rst_b",   1,0,1, 0,0, 0,0, 32'h0,    0,0,0,0, 0));
    step(mk("rst_c",   1,0,1, 0,0, 0,0, 32'h1000, 1,0,1,0));
    step(mk("hb0",     0,0,1, 1,32'h44, 0,0, 32'h1000, 1,0,1,0));
    step(mk("hb1",     0,0,1, 0,0, 0,0, 32'h1000, 1,0,1,0));
    step(mk("hrun",    0,0,1, 0,0, 0,0, 32'h1004, 1,1,0,0));

    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
